// File: rtl/basketball_pkg.sv
// Shared definitions for the basketball LED bar producer side.
// Contents:
//   BASE_OFFSET - value on reg_C that means zero shots
//   MAX_SHOTS   - shot count that fills a round
//   CNT_W       - width of the internal shot counter
//   state_t     - round FSM encoding (IDLE, PLAY, FULL)
package basketball_pkg;

  localparam int BASE_OFFSET = 16;
  localparam int MAX_SHOTS   = 8;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    FULL = 2'd2
  } state_t;

endpackage

// File: rtl/shot_debounce.sv
// Hoop sensor conditioning: 2-flop synchronizer, level debouncer and
// rising-edge detector on the debounced level.
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   raw   - asynchronous sensor input, 1 = ball present
//   level - debounced sensor level
//   rise  - high for one cycle after the debounced level goes 0->1
module shot_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  logic          sync1, sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 != level) begin
        // The DB_CYCLES-th consecutive differing sample is the one that
        // commits the new level, so compare against DB_CYCLES-1 here.
        if (cnt == CW'(DB_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // Combinational so the FSM consumes the edge on the very next clock.
  assign rise = level & ~level_d;

endmodule

// File: rtl/shot_counter.sv
// Shot counter for the basketball LED bar. Debounces the hoop sensor,
// counts scored shots during a round and drives reg_C = BASE + count.
// Optional feature macro: SHOT_TIMER_EN (round also ends after
// TIME_LIMIT cycles in PLAY).
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   start    - one-cycle pulse, arms or restarts a round
//   shot_in  - raw hoop sensor, 1 = ball present
//   reg_C    - offset shot count, BASE + N
//   playing  - round accepting shots (state PLAY)
//   done     - round ended (state FULL)
//   shot_ack - one-cycle pulse per counted shot
module shot_counter #(
  parameter int DB_CYCLES  = 4,
  parameter int BASE       = basketball_pkg::BASE_OFFSET,
  parameter int MAX_SHOTS  = basketball_pkg::MAX_SHOTS,
  parameter int TIME_LIMIT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       shot_in,
  output logic [7:0] reg_C,
  output logic       playing,
  output logic       done,
  output logic       shot_ack
);
  import basketball_pkg::*;

  localparam logic [7:0]       BASE8   = 8'(BASE);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SHOTS);

  if (DB_CYCLES < 2 || TIME_LIMIT < 2) begin : g_param_chk
    $error("shot_counter: DB_CYCLES and TIME_LIMIT must be at least 2");
  end

  logic             level, rise;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + 1'b1;

  shot_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
    .clk  (clk),
    .rst  (rst),
    .raw  (shot_in),
    .level(level),
    .rise (rise)
  );

`ifdef SHOT_TIMER_EN
  localparam int TMR_W = $clog2(TIME_LIMIT);
  logic [TMR_W-1:0] timer;
`endif

  // Round FSM; playing/done are registered alongside the state so they
  // always track it without a decode delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      reg_C    <= BASE8;
      playing  <= 1'b0;
      done     <= 1'b0;
      shot_ack <= 1'b0;
`ifdef SHOT_TIMER_EN
      timer    <= '0;
`endif
    end else begin
      shot_ack <= 1'b0;
      if (start) begin
        // start beats any coincident shot: the round restarts empty.
        state   <= PLAY;
        cnt     <= '0;
        reg_C   <= BASE8;
        playing <= 1'b1;
        done    <= 1'b0;
`ifdef SHOT_TIMER_EN
        timer   <= '0;
`endif
      end else begin
        case (state)
          PLAY: begin
            if (rise) begin
              cnt      <= cnt_inc;
              reg_C    <= BASE8 + {{(8-CNT_W){1'b0}}, cnt_inc};
              shot_ack <= 1'b1;
              if (cnt_inc == MAX_CNT) begin
                state   <= FULL;
                playing <= 1'b0;
                done    <= 1'b1;
              end
            end
`ifdef SHOT_TIMER_EN
            // A shot on the expiry cycle is still counted above.
            timer <= timer + 1'b1;
            if (timer == TMR_W'(TIME_LIMIT - 1)) begin
              state   <= FULL;
              playing <= 1'b0;
              done    <= 1'b1;
            end
`endif
          end
          default: ;  // IDLE waits for start, FULL holds its count
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shot_counter.sv
module tb_shot_counter;

`ifdef SHOT_TIMER_EN
  localparam int TL = 50;
`else
  localparam int TL = 1000;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       shot_in = 1'b0;
  logic [7:0] reg_C;
  logic       playing, done, shot_ack;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acks  = 0;

  shot_counter #(.DB_CYCLES(4), .BASE(16), .MAX_SHOTS(8), .TIME_LIMIT(TL)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .shot_in (shot_in),
    .reg_C   (reg_C),
    .playing (playing),
    .done    (done),
    .shot_ack(shot_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (shot_ack === 1'b1) acks++;

  typedef struct {
    logic       rst;
    logic       start;
    logic       shot;
    logic [7:0] reg_c;
    logic       playing;
    logic       done;
    logic       ack;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, s, sh, input logic [7:0] rc,
                     input logic p, d, a, input int n);
    for (int i = 0; i < n; i++) tbl.push_back('{r, s, sh, rc, p, d, a});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int rc, input int p, input int d, input int a);
    chk({name, ".reg_C"}, int'(reg_C), rc);
    chk({name, ".playing"}, int'(playing), p);
    chk({name, ".done"}, int'(done), d);
    chk({name, ".shot_ack"}, int'(shot_ack), a);
  endtask

  // Ball present 10 cycles then gone 10; update expected on the 7th edge.
  task automatic clean_shot(input string name, input int exp_rc, input int exp_ack);
    shot_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk({name, ".early_ack"}, int'(shot_ack), 0);
    end
    tick;
    chk({name, ".reg_C"}, int'(reg_C), exp_rc);
    chk({name, ".shot_ack"}, int'(shot_ack), exp_ack);
    repeat (3) tick;
    shot_in = 1'b0;
    repeat (10) tick;
  endtask

  initial begin
    int a0;

    // Reset, idle with toggling sensor, start, one clean shot, bounce.
    add(1, 0, 1, 16, 0, 0, 0, 1);
    add(1, 0, 0, 16, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) add(0, 0, (i % 2 == 0), 16, 0, 0, 0, 1);
    add(0, 1, 0, 16, 1, 0, 0, 1);
    add(0, 0, 1, 16, 1, 0, 0, 6);
    add(0, 0, 1, 17, 1, 0, 1, 1);
    add(0, 0, 1, 17, 1, 0, 0, 3);
    add(0, 0, 0, 17, 1, 0, 0, 10);
    add(0, 0, 1, 17, 1, 0, 0, 3);
    add(0, 0, 0, 17, 1, 0, 0, 1);
    add(0, 0, 1, 17, 1, 0, 0, 2);
    add(0, 0, 0, 17, 1, 0, 0, 6);

    for (int i = 0; i < tbl.size(); i++) begin
      rst     = tbl[i].rst;
      start   = tbl[i].start;
      shot_in = tbl[i].shot;
      tick;
      chk_out($sformatf("vec%0d", i), int'(tbl[i].reg_c), int'(tbl[i].playing),
              int'(tbl[i].done), int'(tbl[i].ack));
    end
    start = 1'b0;
    chk("vec.ack_count", acks, 1);

`ifndef SHOT_TIMER_EN
    clean_shot("shot2", 18, 1);
    clean_shot("shot3", 19, 1);
    chk("shots.ack_count", acks, 3);

    // Saturation at BASE+MAX_SHOTS.
    start = 1'b1; tick; start = 1'b0;
    chk_out("sat_start", 16, 1, 0, 0);
    a0 = acks;
    for (int k = 1; k <= 10; k++) begin
      clean_shot($sformatf("sat%0d", k), (k <= 8) ? 16 + k : 24, (k <= 8) ? 1 : 0);
      if (k == 8) chk_out("sat_full", 24, 0, 1, 0);
    end
    chk_out("sat_end", 24, 0, 1, 0);
    chk("sat.ack_count", acks - a0, 8);

    // Restart in FULL coinciding with a debounced rise.
    shot_in = 1'b1;
    repeat (6) tick;
    start = 1'b1; tick; start = 1'b0;
    chk_out("coll_full", 16, 1, 0, 0);
    tick;
    chk_out("coll_full+1", 16, 1, 0, 0);
    repeat (2) tick;
    shot_in = 1'b0;
    repeat (10) tick;

    // Same collision while in PLAY: start still wins.
    shot_in = 1'b1;
    repeat (6) tick;
    start = 1'b1; tick; start = 1'b0;
    chk_out("coll_play", 16, 1, 0, 0);
    repeat (3) tick;
    shot_in = 1'b0;
    repeat (10) tick;
    clean_shot("after_coll", 17, 1);

    // Reset mid-round with the ball held: counted only after a fresh rise.
    shot_in = 1'b1;
    repeat (3) tick;
    rst = 1'b1; tick; rst = 1'b0;
    chk_out("mid_rst", 16, 0, 0, 0);
    start = 1'b1; tick; start = 1'b0;
    chk_out("rst_start", 16, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("held.early_ack", int'(shot_ack), 0);
    end
    tick;
    chk_out("held_count", 17, 1, 0, 1);
    shot_in = 1'b0;
    repeat (10) tick;
`else
    // Timer ends the round 50 cycles after entering PLAY.
    rst = 1'b1; tick; rst = 1'b0;
    chk_out("tmr_rst", 16, 0, 0, 0);
    start = 1'b1; tick; start = 1'b0;
    a0 = cyc;
    clean_shot("tmr_shot1", 17, 1);
    clean_shot("tmr_shot2", 18, 1);
    while (cyc - a0 < 49) begin
      tick;
      chk("tmr.early_done", int'(done), 0);
    end
    tick;
    chk_out("tmr_expire", 18, 0, 1, 0);
    repeat (5) tick;
    chk_out("tmr_hold", 18, 0, 1, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shot_counter.md
Name: shot_counter

Overview:
- Producer side of the basketball LED bar interface: debounces the hoop sensor, counts scored shots and drives the offset-encoded 8-bit count `reg_C` consumed by the LED bar decoder.
- Encoding on `reg_C`: BASE (16) means zero shots; BASE+N means N shots; N is 0..8.
- Sits between the sensor input pin and the LED bar decoder; a start button arms a round.

Parameters:
- DB_CYCLES, 4, consecutive stable samples required to accept a sensor level change (min 2).
- BASE, 16, offset added to the shot count on `reg_C`.
- MAX_SHOTS, 8, shot count at which the round is full.
- TIME_LIMIT, 1000, round length in clk cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse, arms/restarts a round.
- shot_in  input  1  raw asynchronous hoop sensor; 1 = ball present.
- reg_C  output  8  offset shot count, BASE+N.
- playing  output  1  high while the round accepts shots.
- done  output  1  high when the round has ended (full or timed out).
- shot_ack  output  1  one-cycle pulse on each counted shot.

Behaviour:
- Reset: `reg_C` = BASE (8'd16), `playing` = 0, `done` = 0, `shot_ack` = 0, state IDLE, debounced level 0, synchronizer flops 0.
- Synchronizer: `shot_in` passes through 2 flops.
- Debounce:
  - A counter increments while the synced level differs from the debounced level and clears when they match.
  - When the counter reaches DB_CYCLES, the debounced level takes the synced level and the counter clears.
- Shot event: a rising edge of the debounced level.
  - Latency from the stable raw rise to the `shot_ack`/`reg_C` update is 2 + DB_CYCLES + 1 cycles.
  - Example: DB_CYCLES=4 gives 7 cycles.
- FSM states are IDLE, PLAY and FULL.
  - IDLE:
    - `start` → PLAY, `reg_C` ← BASE.
    - Shot events are ignored.
  - PLAY:
    - A shot event causes `reg_C` ← `reg_C`+1 and `shot_ack`=1 for 1 cycle.
    - If the new count equals BASE+MAX_SHOTS, the FSM goes to FULL in the same update.
  - FULL:
    - `done`=1; `reg_C` holds BASE+MAX_SHOTS (24).
    - Further shots are ignored; no `shot_ack`.
- `playing` = (state==PLAY); `done` = (state==FULL). Both are registered decodes of state.
- `start` in PLAY or FULL restarts the round: `reg_C` ← BASE, state PLAY, `done` cleared next cycle.
- Simultaneous `start` and shot event: `start` wins, the shot is discarded, `reg_C`=BASE.
- Saturation: `reg_C` never exceeds BASE+MAX_SHOTS.
- `rst` mid-round: all outputs return to reset values next cycle. The debouncer also resets, so a ball held in the hoop is counted only after a fresh debounced rise.
- Arithmetic: the count is held internally in 4 bits. `reg_C` = BASE + count, zero-extended to 8 bits, registered.

Optional Feature:
- Macro: SHOT_TIMER_EN.
- Defined:
  - A cycle timer clears on entering PLAY and increments each PLAY cycle.
  - When it reaches TIME_LIMIT-1, the FSM goes to FULL (done=1) and `reg_C` holds its current value.
  - A shot on that same cycle is still counted.
- Undefined:
  - No timer logic; the round ends only at MAX_SHOTS.
  - TIME_LIMIT is unused.

Decomposition:
- Package `basketball_pkg`:
  - constants BASE_OFFSET=16, MAX_SHOTS=8, CNT_W=4;
  - state typedef {IDLE, PLAY, FULL}.
- Sub-module `shot_debounce`: synchronizer, debounce counter and rising-edge pulse. Ports: clk, rst, raw, level, rise.
- Top module: FSM, count register and optional timer.

Test Plan:
- Reset then idle: rst 2 cycles, shot_in toggling → `reg_C`=16, playing=0, done=0, no `shot_ack`.
- start, then 3 clean shots (each high 10 cycles, low 10 cycles) → `reg_C` 17, 18, 19; each update 7 cycles after the rise (DB_CYCLES=4); 3 `shot_ack` pulses.
- Bounce rejection: shot_in high 3 cycles, low 1, high 2 cycles → no count, `reg_C` unchanged.
- Saturation: 10 clean shots after start → `reg_C`=24 after the 8th, done=1, playing=0, shots 9–10 ignored.
- Restart collision: in FULL, pulse start on the same cycle as a debounced shot rise → next cycle `reg_C`=16, playing=1, no `shot_ack`.
- With SHOT_TIMER_EN, TIME_LIMIT=50: start, 2 shots, then wait → done=1 exactly 50 cycles after entering PLAY, `reg_C`=18 held.
